interrupt_controller: RTL

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/interrupt_controller.sv
// Interrupt controller: synchronises four level requests, arbitrates by fixed
// priority at instruction boundaries, and steers the sequencer to a vector.
module interrupt_controller (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        FETCH,
  input  logic        DECODE,
  input  logic        EXECUTE,
  input  logic        COMMIT,
  input  logic        EIX,
  input  logic        DIX,
  input  logic        RETIX,
  input  logic        PC_ENX,
  input  logic [3:0]  IRQ,
  input  logic [3:0]  INT_MASK,
  output logic        INT_REQ,
  output logic [15:0] INT_VECTOR,
  output logic [3:0]  INT_ACK,
  output logic        IE,
  output logic        IN_SERVICE,
  output logic        WAKE
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  sync1_reg, sync2_reg;
  logic [1:0]  idx_reg, idx_next;
  logic        ie_reg, ie_next;
  logic        ei_pend_reg, ei_pend_next;
  logic [3:0]  ack_reg, ack_next;
  logic        wake_reg, wake_next;
  logic [3:0]  pending;
  logic [1:0]  first_idx;
  logic        take_point;

  // Phase strobes other than FETCH/COMMIT carry no meaning for this block.
  logic unused_phases;
  assign unused_phases = DECODE ^ EXECUTE;

  assign pending    = sync2_reg & INT_MASK;
  assign take_point = COMMIT || !PC_ENX;

  // Two-flop synchroniser for the asynchronous request lines.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= IRQ;
      sync2_reg <= sync1_reg;
    end
  end

  // Fixed priority: the lowest-numbered pending line wins.
  always_comb begin
    first_idx = 2'd0;
    casez (pending)
      4'b???1: first_idx = 2'd0;
      4'b??10: first_idx = 2'd1;
      4'b?100: first_idx = 2'd2;
      4'b1000: first_idx = 2'd3;
      default: first_idx = 2'd0;
    endcase
  end

  // Control state, latched index, enable flags and the one-cycle pulses.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg   <= IDLE;
      idx_reg     <= 2'd0;
      ie_reg      <= 1'b0;
      ei_pend_reg <= 1'b0;
      ack_reg     <= '0;
      wake_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      ie_reg      <= ie_next;
      ei_pend_reg <= ei_pend_next;
      ack_reg     <= ack_next;
      wake_reg    <= wake_next;
    end
  end

  // Next-state logic; DIX is applied last so it overrides any IE set.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    ie_next      = ie_reg;
    ei_pend_next = ei_pend_reg;
    ack_next     = '0;
    wake_next    = 1'b0;

    // A deferred EIX takes effect at the commit of the following instruction.
    if (ei_pend_reg && COMMIT) begin
      ie_next      = 1'b1;
      ei_pend_next = 1'b0;
    end
    if (EIX && (state_reg != SERVICE)) begin
      ei_pend_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (take_point && ie_reg && (pending != 4'd0) && !DIX) begin
          state_next = PENDING;
          idx_next   = first_idx;
          wake_next  = !PC_ENX;
        end
      end
      PENDING: begin
        if (DIX) begin
          state_next = IDLE;
        end else if (FETCH) begin
          state_next   = SERVICE;
          ack_next     = 4'b0001 << idx_reg;
          ie_next      = 1'b0;
          ei_pend_next = 1'b0;
        end
      end
      SERVICE: begin
        if (RETIX) begin
          state_next = IDLE;
          ie_next    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (DIX) begin
      ie_next      = 1'b0;
      ei_pend_next = 1'b0;
    end
  end

  // Output decode from registered state.
  always_comb begin
    INT_REQ    = (state_reg == PENDING);
    IN_SERVICE = (state_reg == SERVICE);
    INT_VECTOR = 16'h0000;
    if (state_reg != IDLE) begin
      INT_VECTOR = 16'h0010 + {12'd0, idx_reg, 2'b00};
    end
    INT_ACK = ack_reg;
    IE      = ie_reg;
    WAKE    = wake_reg;
  end

endmodule
